// File: rtl/bit_count_unit_if.sv
// Request/response bundle for bit_count_unit.
// BIT_COUNT_WORD_EN adds the word_mode request field.
interface bit_count_unit_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] y;
`ifdef BIT_COUNT_WORD_EN
    logic             word_mode;

    modport master (
        output in_valid, a, op, word_mode, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, a, op, word_mode, out_ready,
        output in_ready, out_valid, y
    );
`else
    modport master (
        output in_valid, a, op, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, a, op, out_ready,
        output in_ready, out_valid, y
    );
`endif
endinterface

// File: rtl/bit_count_unit.sv
// Iterative clz/ctz/cpop unit, CHUNK bits per BUSY cycle.
// clz is computed as ctz of the bit-reversed operand so both share one path.
// Optional macro BIT_COUNT_WORD_EN adds word_mode (clzw/ctzw/cpopw, needs WIDTH>=64).
module bit_count_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            rst_n,
    bit_count_unit_if.slave bus
);
    localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
    localparam int unsigned ITER_W     = $clog2(NUM_CHUNKS) + 1;
    localparam int unsigned CW         = $clog2(CHUNK) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               pop_q, pop_d;
`ifdef BIT_COUNT_WORD_EN
    logic               word_q, word_d;
`endif

    logic [CHUNK-1:0]   chunk;
    logic [WIDTH-1:0]   sr_shift;
    logic [WIDTH-1:0]   load_sr;
    logic [ITER_W-1:0]  last_iter;
    logic               is_clz;

    function automatic logic [CW-1:0] chunk_tz(input logic [CHUNK-1:0] c);
        logic [CW-1:0] tz;
        tz = CW'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (c[i]) tz = CW'(i);
        end
        return tz;
    endfunction

    function automatic logic [CW-1:0] chunk_pop(input logic [CHUNK-1:0] c);
        logic [CW-1:0] sum;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum = sum + CW'(c[i]);
        end
        return sum;
    endfunction

    assign chunk    = sr_q[CHUNK-1:0];
    assign sr_shift = sr_q >> CHUNK;
    assign is_clz   = (bus.op != 2'b01) && (bus.op != 2'b10);

    // Operand as loaded into the shift register; clz operands are bit-reversed.
    always_comb begin
        load_sr = bus.a;
`ifdef BIT_COUNT_WORD_EN
        if (bus.word_mode) begin
            load_sr = {{(WIDTH-32){1'b0}}, bus.a[31:0]};
            if (is_clz) begin
                for (int i = 0; i < 32; i++) load_sr[i] = bus.a[31-i];
            end
        end else if (is_clz) begin
            for (int i = 0; i < WIDTH; i++) load_sr[i] = bus.a[WIDTH-1-i];
        end
`else
        if (is_clz) begin
            for (int i = 0; i < WIDTH; i++) load_sr[i] = bus.a[WIDTH-1-i];
        end
`endif
    end

`ifdef BIT_COUNT_WORD_EN
    assign last_iter = word_q ? ITER_W'(32 / CHUNK - 1) : ITER_W'(NUM_CHUNKS - 1);
`else
    assign last_iter = ITER_W'(NUM_CHUNKS - 1);
`endif

    // Next-state logic: accept, per-chunk accumulate, and result hand-off.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        pop_d   = pop_q;
`ifdef BIT_COUNT_WORD_EN
        word_d  = word_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sr_d    = load_sr;
                    pop_d   = (bus.op == 2'b10);
                    cnt_d   = '0;
                    iter_d  = '0;
`ifdef BIT_COUNT_WORD_EN
                    word_d  = bus.word_mode;
`endif
                    state_d = StBusy;
                end
            end
            StBusy: begin
                sr_d   = sr_shift;
                iter_d = iter_q + ITER_W'(1);
                if (pop_q) begin
                    cnt_d = cnt_q + CNT_W'(chunk_pop(chunk));
                    // Remaining bits all zero means nothing more to count.
                    if (sr_shift == '0 || iter_q == last_iter) state_d = StDone;
                end else if (chunk != '0) begin
                    cnt_d   = cnt_q + CNT_W'(chunk_tz(chunk));
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(CHUNK);
                    if (iter_q == last_iter) state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            pop_q   <= 1'b0;
`ifdef BIT_COUNT_WORD_EN
            word_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            pop_q   <= pop_d;
`ifdef BIT_COUNT_WORD_EN
            word_q  <= word_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.y         = cnt_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Self-checking bench for bit_count_unit (WIDTH=64, CHUNK=8).
module tb_bit_count_unit;
    localparam int unsigned W = 64;
    localparam int unsigned C = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bit_count_unit_if #(.WIDTH(W)) bus ();

    bit_count_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [1:0]  op;
        int          exp_y;
        int          exp_cyc;
    } vec_t;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference result from the instruction definitions.
    function automatic int model_y(input logic [63:0] a, input logic [1:0] op, input logic word);
        int w;
        int n;
        w = word ? 32 : 64;
        n = 0;
        if (op == 2'b10) begin
            for (int i = 0; i < w; i++) n += int'(a[i]);
        end else if (op == 2'b01) begin
            for (int i = 0; i < w; i++) begin
                if (a[i]) break;
                n++;
            end
        end else begin
            for (int i = w - 1; i >= 0; i--) begin
                if (a[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    // Reference BUSY-cycle count: stop at the chunk holding the deciding bit.
    function automatic int model_cyc(input logic [63:0] a, input logic [1:0] op, input logic word);
        int w;
        int z;
        int h;
        w = word ? 32 : 64;
        if (op == 2'b10) begin
            h = -1;
            for (int i = 0; i < w; i++) if (a[i]) h = i;
            return (h < 0) ? 1 : h / C + 1;
        end
        z = model_y(a, op, word);
        return (z == w) ? w / C : z / C + 1;
    endfunction

    // Called at the negedge of the first BUSY cycle.
    task automatic wait_result(input int exp_y, input int exp_cyc, input string nm,
                               input bit release_out);
        int cyc;
        bit rdy_seen;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({nm, " in_ready low while busy"}, rdy_seen, 0);
        check({nm, " busy cycles"}, cyc, exp_cyc);
        check({nm, " y"}, bus.y, exp_y);
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({nm, " out_valid drop"}, bus.out_valid, 0);
            check({nm, " in_ready back"}, bus.in_ready, 1);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [1:0] op, input logic word,
                          input int exp_y, input int exp_cyc, input string nm,
                          input bit release_out);
        int g;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            g++;
            @(negedge clk);
        end
        check({nm, " ready to accept"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.op       = op;
`ifdef BIT_COUNT_WORD_EN
        bus.word_mode = word;
`else
        if (word) $display("note: word request %s issued without word support", nm);
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.op       = 2'($urandom_range(0, 3));
        wait_result(exp_y, exp_cyc, nm, release_out);
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] ra;
        logic [1:0]  rop;
        logic        rw;
        total = 0;
        bad   = 0;

        vecs.push_back('{64'h0000_0000_0001_0000, 2'b00, 47, 6});
        vecs.push_back('{64'h0,                   2'b01, 64, 8});
        vecs.push_back('{64'h8000_0000_0000_0000, 2'b01, 63, 8});
        vecs.push_back('{64'h0000_0000_0000_0100, 2'b01,  8, 2});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64, 8});
        vecs.push_back('{64'h0F,                  2'b10,  4, 1});
        vecs.push_back('{64'h8000_0000_0000_0000, 2'b11,  0, 1});
        vecs.push_back('{64'h0,                   2'b00, 64, 8});
        vecs.push_back('{64'h0,                   2'b10,  0, 1});

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
`ifdef BIT_COUNT_WORD_EN
        bus.word_mode = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset y", bus.y, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].op, 1'b0, vecs[i].exp_y, vecs[i].exp_cyc,
                   $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: result must hold and new request must wait.
        run_op(64'h1, 2'b00, 1'b0, 63, 8, "bp clz", 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 64'h100;
        bus.op       = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp out_valid held", bus.out_valid, 1);
            check("bp y held", bus.y, 63);
            check("bp in_ready low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp idle out_valid", bus.out_valid, 0);
        check("bp idle in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp new accepted", bus.in_ready, 0);
        wait_result(8, 2, "bp ctz", 1'b1);

        // Reset during BUSY discards the in-flight cpop.
        bus.in_valid = 1'b1;
        bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op       = 2'b10;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst out_valid", bus.out_valid, 0);
        check("rst y", bus.y, 0);
        check("rst in_ready", bus.in_ready, 1);
        run_op(64'h10, 2'b01, 1'b0, 4, 1, "post-rst ctz", 1'b1);

`ifdef BIT_COUNT_WORD_EN
        run_op(64'hFFFF_FFFF_0000_0001, 2'b00, 1'b1, 31, 4, "clzw", 1'b1);
        run_op(64'hFFFF_FFFF_0000_0001, 2'b10, 1'b1,  1, 1, "cpopw", 1'b1);
        run_op(64'hFFFF_FFFF_0000_0000, 2'b01, 1'b1, 32, 4, "ctzw", 1'b1);
`endif

        for (int k = 0; k < 60; k++) begin
            ra  = {$urandom, $urandom};
            ra  = (k % 2 == 0) ? ra >> $urandom_range(0, 63) : ra << $urandom_range(0, 63);
            if (k % 7 == 0) ra = '0;
            rop = 2'($urandom_range(0, 3));
`ifdef BIT_COUNT_WORD_EN
            rw  = 1'($urandom_range(0, 1));
`else
            rw  = 1'b0;
`endif
            run_op(ra, rop, rw, model_y(ra, rop, rw), model_cyc(ra, rop, rw),
                   $sformatf("rnd%0d", k), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
